// File: rtl/aes_key_expander_if.sv
// Bundle between the key expander and the encipher core: key load,
// round-key lookup and the shared S-box word port.
//   Handshake: `init` is a one-cycle request that the expander samples
//   only while `ready` is high. It is accepted on the clock edge at
//   which both are high, and `ready` drops on that same edge. `ready`
//   rises again once every round key is stored. `round`/`round_key` form
//   a pure combinational lookup with no handshake. `sboxw` feeds an S-box
//   that must return `new_sboxw` in the same cycle.
interface aes_key_expander_if;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic         dbg_generate;   // 1 while the FSM is in GENERATE

    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, ready, sboxw, dbg_generate
    );

    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, ready, sboxw, dbg_generate
    );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/AES-256 key schedule. It expands the cipher key into 11 or 15
// round keys, one per cycle, and keeps them in a local memory. The
// memory is read combinationally by round index.
module aes_key_expander (
    input  logic                  clk,
    input  logic                  reset_n,
    aes_key_expander_if.slave     kx
);

    typedef enum logic {
        IDLE     = 1'b0,
        GENERATE = 1'b1
    } state_t;

    state_t         state_q;
    logic [127:0]   key_mem_q [15];
    logic [255:0]   key_q;
    logic           keylen_q;
    logic [3:0]     round_ctr_q;
    logic [7:0]     rcon_q;
    logic [127:0]   prev1_q;
    logic [127:0]   prev2_q;
    logic           ready_q;

    logic [7:0]     rcon_d;
    logic           use_rcon;
    logic           raw_write;
    logic           last_round;
    logic [31:0]    t_word;
    logic [127:0]   base;
    logic [31:0]    w0, w1, w2, w3;
    logic [127:0]   new_key_d;

    // Next round key. It comes from the cipher key (first one or two
    // slots) or from prev1/prev2 plus the S-box result.
    always_comb begin
        rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        // AES-256 odd rounds use SubWord only: no rotate, no rcon.
        use_rcon   = !keylen_q || !round_ctr_q[0];
        raw_write  = (round_ctr_q == 4'd0) || ((round_ctr_q == 4'd1) && keylen_q);
        last_round = (round_ctr_q == (keylen_q ? 4'd14 : 4'd10));
        t_word     = use_rcon ? ({kx.new_sboxw[23:0], kx.new_sboxw[31:24]} ^ {rcon_d, 24'h0})
                              : kx.new_sboxw;
        base       = keylen_q ? prev2_q : prev1_q;
        w0         = base[127:96] ^ t_word;
        w1         = base[95:64]  ^ w0;
        w2         = base[63:32]  ^ w1;
        w3         = base[31:0]   ^ w2;
        if (round_ctr_q == 4'd0)
            new_key_d = key_q[255:128];
        else if ((round_ctr_q == 4'd1) && keylen_q)
            new_key_d = key_q[127:0];
        else
            new_key_d = {w0, w1, w2, w3};
    end

    // FSM: latch the key on init, then write one round key per cycle until the last.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++)
                key_mem_q[i] <= '0;
            key_q       <= '0;
            keylen_q    <= 1'b0;
            round_ctr_q <= 4'd0;
            rcon_q      <= 8'h8d;
            prev1_q     <= '0;
            prev2_q     <= '0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (kx.init) begin
                        key_q       <= kx.key;
                        keylen_q    <= kx.keylen;
                        round_ctr_q <= 4'd0;
                        rcon_q      <= 8'h8d;   // gm2(8d) = 01 on first use
                        ready_q     <= 1'b0;
                        state_q     <= GENERATE;
                    end
                end
                GENERATE: begin
                    key_mem_q[round_ctr_q] <= new_key_d;
                    prev2_q     <= prev1_q;
                    prev1_q     <= new_key_d;
                    round_ctr_q <= round_ctr_q + 4'd1;
                    if (!raw_write && use_rcon)
                        rcon_q <= rcon_d;
                    if (last_round) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // prev1.w3 goes to the S-box for all of GENERATE; it is ignored on raw-copy cycles.
    assign kx.sboxw        = (state_q == GENERATE) ? prev1_q[31:0] : 32'h0;
    assign kx.round_key    = (kx.round == 4'd15) ? 128'h0 : key_mem_q[kx.round];
    assign kx.ready        = ready_q;
    assign kx.dbg_generate = (state_q == GENERATE);

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Key-schedule stage directly upstream of the encipher round block.
- On `init`, expands a 128- or 256-bit cipher key into 11 or 15 round keys, one 128-bit round key per cycle.
- Stores the round keys in an internal key memory. Serves `round_key` combinationally for the round index the encipher block presents.
- Uses the core's shared 32-bit S-box through an `sboxw`/`new_sboxw` port pair. The top level gives it the S-box while `ready` is low.

Parameters:
- None. Key lengths fixed at AES-128 (keylen=0, 10 rounds) and AES-256 (keylen=1, 14 rounds).

Ports:
- clk  input  1  system clock; all registers update on its rising edge
- reset_n  input  1  reset, synchronous, active-low
- init  input  1  start key expansion; single-cycle pulse, sampled only in IDLE
- key  input  256  cipher key; AES-128 uses key[255:128], key[127:0] ignored
- keylen  input  1  0 = AES-128, 1 = AES-256; sampled with init
- round  input  4  round-key index requested by the encipher block
- round_key  output  128  key_mem[round]; combinational read
- ready  output  1  1 = idle, all round keys valid
- sboxw  output  32  word to S-box
- new_sboxw  input  32  S-box result of sboxw, combinational, same cycle

Behaviour:
- Storage and registers:
  - key_mem: 15 x 128-bit entries.
  - Registers: key_reg (256), keylen_reg, round_ctr (4), rcon_reg (8), prev1_reg (128, last written key), prev2_reg (128, key written before that), ready_reg, state.
- Reset (reset_n=0 at a clk edge):
  - All key_mem entries, prev1, prev2 and key_reg = 0.
  - round_ctr=0, rcon=8'h8d, ready=1, state=IDLE.
  - Reset mid-expansion aborts; no partial keys remain.
- States: IDLE, GENERATE.
- IDLE:
  - sboxw=0.
  - On init=1: latch key/keylen, round_ctr<=0, rcon<=8'h8d, ready<=0, go to GENERATE.
- GENERATE, one key_mem write per cycle at index round_ctr, then round_ctr+1:
  - r=0: write key_reg[255:128].
  - r=1:
    - keylen=1: write key_reg[127:0].
    - keylen=0: generate as below.
  - Generate step:
    - x = prev1.w3; sboxw = x; s = new_sboxw.
    - AES-128, or AES-256 with even r: rcon<=gm2(rcon), using the updated value {01,02,04,...,1b,36}. t = {s[23:0],s[31:24]} ^ {rcon_next,24'h0}.
    - AES-256 with odd r>=3: t = s; rcon unchanged.
    - base = prev1 for AES-128, prev2 for AES-256.
    - w0 = base.w0^t; w1 = base.w1^w0; w2 = base.w2^w1; w3 = base.w3^w2. w0 is bits [127:96].
  - After each write: prev2<=prev1, prev1<=written key.
  - When round_ctr == num_rounds (10 or 14): final write, ready<=1, state<=IDLE.
  - sboxw = prev1.w3 for the whole of GENERATE. This is harmless in cycles where the result is unused.
- Latency:
  - ready is low for exactly 11 cycles (AES-128) or 15 cycles (AES-256) after the init edge.
  - key_mem[r] is valid from the edge following its write.
- init while ready=0: ignored; no restart, and key/keylen changes have no effect.
- round_key:
  - Combinational key_mem[round] in every state.
  - round=15 returns 128'h0.
  - Indices beyond the current key's num_rounds return stale or zero data; the encipher block never requests them.
- keylen changes while idle have no effect until the next init.

Test Plan:
- Reset: hold reset_n=0 two cycles -> ready=1; round_key=0 for round 0..15; sboxw=0.
- AES-128 (FIPS-197 A.1), key[255:128]=2b7e151628aed2a6abf7158809cf4f3c, keylen=0, init pulse:
  - ready low exactly 11 cycles.
  - round 0 -> 2b7e1516..., round 1 -> a0fafe1788542cb123a339392a6c7605, round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-256 (FIPS-197 A.3), key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, keylen=1:
  - ready low exactly 15 cycles.
  - round 1 -> 1f352c073b6108d72d9810a30914dff4, round 2 -> 9ba354118e6925afa51a8b5f2067fcde, round 14 -> fe4890d1e6188d0b046df344706c631e.
- init re-pulsed at cycle 5 of the AES-128 run with a different key and keylen=1 -> ignored; still 11 cycles; round 10 = d014f9a8...
- reset_n=0 at cycle 6 of the AES-256 run -> next cycle ready=1, all round_key=0. A fresh AES-128 init then completes correctly.
- Back-to-back: AES-256 expansion then immediately AES-128 -> rcon restarts at 01; round 10 = d014f9a8...; round 11..14 stale.
